// File: rtl/piso_pkg.sv
// Shared types and limits for the PISO serializer controller and its shift register.
package piso_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;
  localparam int unsigned GAP_MAX   = 15;
  localparam int unsigned GAP_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width <= WIDTH_MIN) begin
      return 32'd1;
    end
    return unsigned'($clog2(width));
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, left-shifting register (zero fill) with async active-low clear.
module piso_shreg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load wins over shift; otherwise hold.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = d_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_serializer_ctrl.sv
// Sequencer for the PISO shifter: word handshake, MSB-first framing, stall and inter-frame gap.
// Define PISO_PARITY_EN to append an even-parity beat to every frame.
module piso_serializer_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             ser_en,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_first,
  output logic             s_last,
  output logic             busy
);

  localparam int unsigned             CNT_W       = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]        CNT_LAST    = CNT_W'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0]    GAP_LAST    = (GAP > 0) ? GAP_CNT_W'(GAP - 1)
                                                              : GAP_CNT_W'(0);
  localparam bit                      ZERO_BUBBLE = (GAP == 0);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX) || (GAP > GAP_MAX)) begin : g_bad_params
    $error("piso_serializer_ctrl: WIDTH must be 2..32 and GAP 0..15");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GAP_CNT_W-1:0]   gcnt_q, gcnt_d;
  logic                   load_c;
  logic                   shift_c;
  logic                   accept_c;
  logic                   end_beat_c;
  logic                   msb;
`ifdef PISO_PARITY_EN
  logic                   par_q, par_d;
`endif

  piso_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_c),
    .shift_i (shift_c),
    .d_i     (in_data),
    .msb_o   (msb)
  );

  // Final beat of a frame is being taken downstream this cycle.
`ifdef PISO_PARITY_EN
  assign end_beat_c = (state_q == ST_PAR) && ser_en;
`else
  assign end_beat_c = (state_q == ST_SHIFT) && (cnt_q == '0) && ser_en;
`endif

  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    load_c  = 1'b0;
    shift_c = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
      end
      ST_SHIFT: begin
        if (ser_en && (cnt_q != '0)) begin
          shift_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
`ifdef PISO_PARITY_EN
        else if (ser_en) begin
          state_d = ST_PAR;
        end
`endif
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
      end
`endif
      ST_GAP: begin
        // Gap length is fixed in cycles; the downstream stall has no effect here.
        if (gcnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q - GAP_CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (end_beat_c) begin
      state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      gcnt_d  = GAP_LAST;
    end

    // A new word may arrive from IDLE or, with no gap, on the frame's final beat.
    if (accept_c) begin
      load_c  = 1'b1;
      cnt_d   = CNT_LAST;
      state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
      par_d   = ^in_data;
`endif
    end
  end

  always_comb begin
    in_ready = 1'b0;
    s_valid  = 1'b0;
    s_out    = 1'b0;
    s_first  = 1'b0;
    s_last   = 1'b0;
    busy     = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_SHIFT: begin
        s_valid  = 1'b1;
        s_out    = msb;
        s_first  = (cnt_q == CNT_LAST);
`ifndef PISO_PARITY_EN
        s_last   = (cnt_q == '0);
`endif
        in_ready = ZERO_BUBBLE && end_beat_c;
      end
`ifdef PISO_PARITY_EN
      ST_PAR: begin
        s_valid  = 1'b1;
        s_out    = par_q;
        s_last   = 1'b1;
        in_ready = ZERO_BUBBLE && end_beat_c;
      end
`endif
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-queue model.
// Instance A runs with GAP=0 (zero-bubble), instance B with GAP=2; both share inputs.
module tb_piso_serializer_ctrl;

  localparam int unsigned W     = 4;
  localparam int          GAP_B = 2;
`ifdef PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FL = int'(W) + (PAR_EN ? 1 : 0);

  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } beat_t;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         in_valid = 1'b0;
  logic         ser_en   = 1'b0;
  logic [W-1:0] in_data  = '0;

  logic a_in_ready, a_s_out, a_s_valid, a_s_first, a_s_last, a_busy;
  logic b_in_ready, b_s_out, b_s_valid, b_s_first, b_s_last, b_busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  piso_serializer_ctrl #(.WIDTH(W), .GAP(0)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_data  (in_data),
    .ser_en   (ser_en),
    .s_out    (a_s_out),
    .s_valid  (a_s_valid),
    .s_first  (a_s_first),
    .s_last   (a_s_last),
    .busy     (a_busy)
  );

  piso_serializer_ctrl #(.WIDTH(W), .GAP(GAP_B)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (b_in_ready),
    .in_data  (in_data),
    .ser_en   (ser_en),
    .s_out    (b_s_out),
    .s_valid  (b_s_valid),
    .s_first  (b_s_first),
    .s_last   (b_s_last),
    .busy     (b_busy)
  );

  // Beat k of the frame carrying word w: data MSB first, then optional parity.
  function automatic beat_t beat_at(input logic [W-1:0] w, input int k);
    beat_t r;
    if (k < int'(W)) begin
      r.b = w[int'(W) - 1 - k];
      r.f = (k == 0);
      r.l = !PAR_EN && (k == int'(W) - 1);
    end else begin
      r.b = ^w;
      r.f = 1'b0;
      r.l = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ser_en   = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++;
    if ({a_s_out, a_s_valid, a_s_first, a_s_last, a_busy, a_in_ready} !== 6'b000001)
      $display("FAIL reset_a: got %b need 000001",
               {a_s_out, a_s_valid, a_s_first, a_s_last, a_busy, a_in_ready});
    else n_pass++;
    n_chk++;
    if ({b_s_out, b_s_valid, b_s_first, b_s_last, b_busy, b_in_ready} !== 6'b000001)
      $display("FAIL reset_b: got %b need 000001",
               {b_s_out, b_s_valid, b_s_first, b_s_last, b_busy, b_in_ready});
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w;
    w = W'(4'hA);
    do_reset();
    in_valid = 1'b1;
    in_data  = w;
    ser_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_s_out} !== {1'b1, w[int'(W) - 1 - k]})
        $display("FAIL midrst_pre beat%0d: got %b need %b", k, {a_s_valid, a_s_out},
                 {1'b1, w[int'(W) - 1 - k]});
      else n_pass++;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_s_out, a_s_valid, a_s_first, a_s_last, a_busy} !== 5'b00000)
      $display("FAIL midrst_async: got %b need 00000",
               {a_s_out, a_s_valid, a_s_first, a_s_last, a_busy});
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_in_ready, a_busy} !== 3'b010)
        $display("FAIL midrst_after c%0d: valid/ready/busy got %b need 010", c,
                 {a_s_valid, a_in_ready, a_busy});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_single_frame();
    logic [W-1:0] w;
    beat_t        e;
    w = W'(4'b1011);
    do_reset();
    in_valid = 1'b1;
    in_data  = w;
    ser_en   = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_in_ready !== 1'b1) $display("FAIL single_idle_ready: got %b need 1", a_in_ready);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      e = beat_at(w, k);
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_s_out, a_s_first, a_s_last} !== {1'b1, e.b, e.f, e.l})
        $display("FAIL single beat%0d: v/o/f/l got %b need %b", k,
                 {a_s_valid, a_s_out, a_s_first, a_s_last}, {1'b1, e.b, e.f, e.l});
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({a_s_valid, a_busy, a_in_ready} !== 3'b001)
      $display("FAIL single_end: valid/busy/ready got %b need 001", {a_s_valid, a_busy, a_in_ready});
    else n_pass++;
    tick();
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    beat_t        e;
    int           idx;
    w   = W'(4'b1011);
    idx = 0;
    do_reset();
    in_valid = 1'b1;
    in_data  = w;
    ser_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < FL + 3; c++) begin
      ser_en = !(c >= 1 && c <= 3);
      e = beat_at(w, idx);
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_s_out, a_s_first, a_s_last} !== {1'b1, e.b, e.f, e.l})
        $display("FAIL stall c%0d: v/o/f/l got %b need %b", c,
                 {a_s_valid, a_s_out, a_s_first, a_s_last}, {1'b1, e.b, e.f, e.l});
      else n_pass++;
      tick();
      if (ser_en) idx++;
    end
    @(negedge clk);
    n_chk++;
    if ({a_s_valid, a_busy} !== 2'b00)
      $display("FAIL stall_end: valid/busy got %b need 00", {a_s_valid, a_busy});
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w;
    beat_t        e;
    do_reset();
    in_valid = 1'b1;
    in_data  = W'(4'hC);
    ser_en   = 1'b1;
    tick();
    for (int k = 1; k <= 2 * FL; k++) begin
      in_valid = (k <= FL);
      in_data  = W'(4'h3);
      w = (k <= FL) ? W'(4'hC) : W'(4'h3);
      e = beat_at(w, (k - 1) % FL);
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_s_out, a_s_first, a_s_last} !== {1'b1, e.b, e.f, e.l})
        $display("FAIL b2b beat%0d: v/o/f/l got %b need %b", k,
                 {a_s_valid, a_s_out, a_s_first, a_s_last}, {1'b1, e.b, e.f, e.l});
      else n_pass++;
      n_chk++;
      if (a_in_ready !== ((k % FL) == 0))
        $display("FAIL b2b_ready beat%0d: got %b need %b", k, a_in_ready, ((k % FL) == 0));
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({a_s_valid, a_in_ready} !== 2'b01)
      $display("FAIL b2b_end: valid/ready got %b need 01", {a_s_valid, a_in_ready});
    else n_pass++;
    tick();
  endtask

  task automatic test_gap();
    logic [W-1:0] w;
    beat_t        e;
    w = W'(4'b1011);
    do_reset();
    in_valid = 1'b1;
    in_data  = w;
    ser_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      e = beat_at(w, k);
      @(negedge clk);
      n_chk++;
      if ({b_s_valid, b_s_out, b_s_first, b_s_last} !== {1'b1, e.b, e.f, e.l})
        $display("FAIL gap_frame beat%0d: v/o/f/l got %b need %b", k,
                 {b_s_valid, b_s_out, b_s_first, b_s_last}, {1'b1, e.b, e.f, e.l});
      else n_pass++;
      tick();
    end
    ser_en = 1'b0;
    for (int g = 0; g < GAP_B; g++) begin
      @(negedge clk);
      n_chk++;
      if ({b_s_valid, b_in_ready, b_busy, b_s_out} !== 4'b0010)
        $display("FAIL gap_cycle%0d: valid/ready/busy/out got %b need 0010", g,
                 {b_s_valid, b_in_ready, b_busy, b_s_out});
      else n_pass++;
      tick();
    end
    @(negedge clk);
    n_chk++;
    if ({b_in_ready, b_busy} !== 2'b10)
      $display("FAIL gap_end: ready/busy got %b need 10", {b_in_ready, b_busy});
    else n_pass++;
    tick();
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity();
    logic [4:0] eb;
    logic [4:0] el;
    eb = 5'b01111;
    el = 5'b00001;
    do_reset();
    in_valid = 1'b1;
    in_data  = W'(4'b0111);
    ser_en   = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++;
      if ({a_s_valid, a_s_out, a_s_last} !== {1'b1, eb[4 - k], el[4 - k]})
        $display("FAIL parity beat%0d: v/o/l got %b need %b", k,
                 {a_s_valid, a_s_out, a_s_last}, {1'b1, eb[4 - k], el[4 - k]});
      else n_pass++;
      tick();
    end
  endtask
`endif

  // Random traffic; each DUT's model is a queue of pending frame beats.
  task automatic test_random();
    beat_t qa[$];
    beat_t qb[$];
    beat_t ea, eb;
    int    gap_b;
    logic  va, ra, vb, rb, bb, lastb;
    gap_b = 0;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      ser_en   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      va = (qa.size() > 0);
      ra = (qa.size() == 0) || ((qa.size() == 1) && ser_en);
      vb = (qb.size() > 0);
      rb = (qb.size() == 0) && (gap_b == 0);
      bb = vb || (gap_b > 0);
      ea = '0;
      eb = '0;
      if (va) ea = qa[0];
      if (vb) eb = qb[0];
      n_chk++;
      if ({a_s_valid, a_s_out, a_s_first, a_s_last, a_in_ready, a_busy} !==
          {va, ea.b, ea.f, ea.l, ra, va})
        $display("FAIL rand_a cyc%0d: v/o/f/l/rdy/busy got %b need %b", cyc,
                 {a_s_valid, a_s_out, a_s_first, a_s_last, a_in_ready, a_busy},
                 {va, ea.b, ea.f, ea.l, ra, va});
      else n_pass++;
      n_chk++;
      if ({b_s_valid, b_s_out, b_s_first, b_s_last, b_in_ready, b_busy} !==
          {vb, eb.b, eb.f, eb.l, rb, bb})
        $display("FAIL rand_b cyc%0d: v/o/f/l/rdy/busy got %b need %b", cyc,
                 {b_s_valid, b_s_out, b_s_first, b_s_last, b_in_ready, b_busy},
                 {vb, eb.b, eb.f, eb.l, rb, bb});
      else n_pass++;
      if (va && ser_en) void'(qa.pop_front());
      if (in_valid && ra) for (int k = 0; k < FL; k++) qa.push_back(beat_at(in_data, k));
      if (gap_b > 0) begin
        gap_b--;
      end else if (vb && ser_en) begin
        lastb = qb[0].l;
        void'(qb.pop_front());
        if (lastb) gap_b = GAP_B;
      end
      if (in_valid && rb) for (int k = 0; k < FL; k++) qb.push_back(beat_at(in_data, k));
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_gap();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
